hilo_muldiv: RTL
================

# hilo_muldiv

Parametrised multi-cycle multiply/divide unit with HI/LO result write-back, sitting beside the combinational execute datapath. It accepts an operation from the execute stage and raises a stall request while it computes. It also accepts signed/unsigned multiply, optional multiply-accumulate, and radix-2 restoring divide. It returns a one-cycle HI/LO write strobe consumed by the HI/LO register file and the forwarding network.

## Interface
- DATA_W, 32: operand width. HI/LO are DATA_W each; product is 2*DATA_W.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- start_i  in  1  operation request; sampled only in IDLE.
- op_i  in  3  opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- opa_i  in  DATA_W  rs operand (dividend / multiplicand).
- opb_i  in  DATA_W  rt operand (divisor / multiplier).
- hi_i, lo_i  in  DATA_W each  forwarded current HI/LO; sampled at accept, used by accumulate ops.
- annul_i  in  1  flush; aborts any operation in progress.
- stallreq_o  out  1  pipeline stall request.
- busy_o  out  1  unit not in IDLE.
- whilo_o  out  1  HI/LO write strobe, one cycle.
- hi_o, lo_o  out  DATA_W each  result; valid only while whilo_o=1, otherwise 0.

## Operation
- States: IDLE, DIV, DONE.
- Accept occurs when start_i=1, annul_i=0 and state=IDLE. At accept, the unit latches opcode, operands, hi_i/lo_i and the sign flags.
  - Multiply ops go to DONE. The full 2*DATA_W product is registered at accept.
  - DIV/DIVU with opb_i≠0 go to DIV with iteration counter = 0.
  - DIV/DIVU with opb_i=0 go to DONE with HI=opa_i, LO=all-ones.
- Signed ops (MULT, DIV, MADD, MSUB) work on magnitudes; the result is negated at the end when needed.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Accumulate: {HI,LO} = {hi,lo} + product (MADD/MADDU) or {hi,lo} − product (MSUB/MSUBU). The arithmetic is modulo 2^(2*DATA_W); no overflow flag.
- DIV state:
  - Each cycle does one shift-subtract step.
  - The counter increments each cycle. The transition to DONE happens after the step with counter = DATA_W−1.
  - Result: LO = quotient, HI = remainder.
- Most-negative / −1 (DIV): quotient wraps to the most-negative value, remainder 0.
- DONE: whilo_o=1 with the result, then return to IDLE on the next edge.
- annul_i=1 in any state: next state IDLE, no whilo_o, result discarded. If annul_i is asserted in DONE, whilo_o is forced to 0 in that cycle.
- start_i while busy is ignored. The stage holding the instruction keeps it stalled, so there is no loss.

## Timing
- Reset values: state IDLE, counter 0, stallreq_o=0, busy_o=0, whilo_o=0, hi_o=0, lo_o=0.
- stallreq_o is combinational:
  - (state=IDLE & start_i & ~annul_i) | state=DIV.
  - It is low in DONE, so the stage advances in the same cycle the result is written.
- Multiply latency: accept in cycle 0, whilo_o in cycle 1.
- Divide latency: accept in cycle 0, DIV in cycles 1..DATA_W, whilo_o in cycle DATA_W+1.
- Divide by zero: whilo_o in cycle 1.
- Back-to-back: a new accept is possible the cycle after DONE (the IDLE cycle).
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously).

## Configuration
- MULDIV_ACC_EN defined: op codes 4–7 (MADD, MADDU, MSUB, MSUBU) are supported as above.
- MULDIV_ACC_EN undefined:
  - Op codes 4–7 are not accepted: the unit stays in IDLE and stallreq_o stays 0.
  - hi_i/lo_i are unused, and the accumulate adder is not built.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release. All outputs are 0 and busy_o=0. Assert rst=0 in the middle of a DIV: all outputs drop to 0 without waiting for a clock edge.
- MULT a=0xFFFFFFFE (−2), b=3: whilo_o one cycle later with HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2: stallreq_o high for 33 cycles (the accept cycle plus 32 DIV cycles); whilo_o in cycle 33 with LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU a=100, b=0: whilo_o at cycle 1 with HI=100, LO=0xFFFFFFFF.
- Accumulate (MULDIV_ACC_EN defined):
  - MADD hi_i=0, lo_i=0xFFFFFFFF, a=1, b=1 gives HI=1, LO=0.
  - MSUBU hi_i=0, lo_i=0, a=1, b=1 gives HI=LO=0xFFFFFFFF.
  - With the macro undefined, op 4 with start_i=1 keeps stallreq_o=0 and never produces whilo_o.
- Annul: start DIVU, assert annul_i in DIV cycle 10. The unit is in IDLE next cycle and whilo_o never pulses. A new MULTU 5×6 in the following cycle gives LO=30, HI=0.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// Execute-stage <-> multiply/divide unit bundle: operation request, forwarded HI/LO,
// flush, stall request and the one-cycle HI/LO write-back.
interface hilo_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [2:0]        op_i;
    logic [DATA_W-1:0] opa_i;
    logic [DATA_W-1:0] opb_i;
    logic [DATA_W-1:0] hi_i;
    logic [DATA_W-1:0] lo_i;
    logic              annul_i;
    logic              stallreq_o;
    logic              busy_o;
    logic              whilo_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output start_i, op_i, opa_i, opb_i, hi_i, lo_i, annul_i,
        input  stallreq_o, busy_o, whilo_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, opa_i, opb_i, hi_i, lo_i, annul_i,
        output stallreq_o, busy_o, whilo_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply / radix-2 restoring divide unit with HI/LO write-back.
// Define MULDIV_ACC_EN to enable MADD/MADDU/MSUB/MSUBU (op codes 4-7).
module hilo_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    hilo_muldiv_if.slave       bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;
    logic [DATA_W-1:0]   dvd;
    logic [DATA_W-1:0]   dvs;
    logic [DATA_W-1:0]   rem;
    logic                neg_q;
    logic                neg_r;

    logic                is_signed;
    logic                is_div;
    logic                op_ok;
    logic                accept;
    logic                sign_a;
    logic                sign_b;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [2*DATA_W-1:0] prod_mag;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] mul_res;

    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     diff;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_nx;
    logic [DATA_W-1:0]   quo_nx;
    logic [DATA_W-1:0]   final_q;
    logic [DATA_W-1:0]   final_r;

    // Signed ops are the even opcodes; everything runs on magnitudes and is re-signed at the end.
    always_comb begin
        is_signed = ~bus.op_i[0];
        is_div    = (bus.op_i[2:1] == 2'b01);
`ifdef MULDIV_ACC_EN
        op_ok     = 1'b1;
`else
        op_ok     = ~bus.op_i[2];
`endif
        accept    = (state == ST_IDLE) && bus.start_i && !bus.annul_i && op_ok;
        sign_a    = is_signed & bus.opa_i[DATA_W-1];
        sign_b    = is_signed & bus.opb_i[DATA_W-1];
        mag_a     = sign_a ? -bus.opa_i : bus.opa_i;
        mag_b     = sign_b ? -bus.opb_i : bus.opb_i;
        prod_mag  = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
        prod      = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
        mul_res   = prod;
`ifdef MULDIV_ACC_EN
        if (bus.op_i[2]) begin
            mul_res = bus.op_i[1] ? ({bus.hi_i, bus.lo_i} - prod)
                                  : ({bus.hi_i, bus.lo_i} + prod);
        end
`endif
    end

`ifndef MULDIV_ACC_EN
    wire unused_acc = ^{bus.hi_i, bus.lo_i};
`endif

    // One restoring shift-subtract step; the dividend register fills with quotient bits from the LSB.
    always_comb begin
        rem_sh  = {rem, dvd[DATA_W-1]};
        diff    = rem_sh - {1'b0, dvs};
        q_bit   = ~diff[DATA_W];
        rem_nx  = q_bit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        quo_nx  = {dvd[DATA_W-2:0], q_bit};
        final_q = neg_q ? -quo_nx : quo_nx;
        final_r = neg_r ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_div) begin
                            if (bus.opb_i == '0) begin
                                res_hi <= bus.opa_i;
                                res_lo <= '1;
                                state  <= ST_DONE;
                            end else begin
                                dvd    <= mag_a;
                                dvs    <= mag_b;
                                rem    <= '0;
                                cnt    <= '0;
                                neg_q  <= sign_a ^ sign_b;
                                neg_r  <= sign_a;
                                state  <= ST_DIV;
                            end
                        end else begin
                            {res_hi, res_lo} <= mul_res;
                            state            <= ST_DONE;
                        end
                    end
                end
                ST_DIV: begin
                    if (bus.annul_i) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        dvd <= quo_nx;
                        rem <= rem_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            res_hi <= final_r;
                            res_lo <= final_q;
                            cnt    <= '0;
                            state  <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stall drops in DONE so the holding stage advances in the write-back cycle.
    always_comb begin
        bus.stallreq_o = accept || (state == ST_DIV);
        bus.busy_o     = (state != ST_IDLE);
        bus.whilo_o    = (state == ST_DONE) && !bus.annul_i;
        bus.hi_o       = bus.whilo_o ? res_hi : '0;
        bus.lo_o       = bus.whilo_o ? res_lo : '0;
    end
endmodule
